// File: rtl/pci_pkg.sv
// Shared definitions for the PCI target: bus width, command codes, target FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pci_pkg;

    localparam int BUS_W = 32;

    localparam logic [3:0] CMD_MEM_WRITE = 4'b0000;
    localparam logic [3:0] CMD_MEM_READ  = 4'b0001;

    typedef enum logic [2:0] {
        IDLE,
        CLAIM,
        WAIT,
        DATA,
        RELEASE
    } tgt_state_e;

    // Only plain memory reads and writes are claimed by the target.
    function automatic logic is_legal_cmd(input logic [3:0] cmd);
        return (cmd == CMD_MEM_WRITE) || (cmd == CMD_MEM_READ);
    endfunction

endpackage

// File: rtl/pci_target_mem.sv
// Local word storage for the PCI target: byte-enable write port plus two async read ports.
// Latency: write lands on the clock edge; both read ports are combinational.
// Backpressure: none; the FSM only raises we on an accepted data phase.
//
// Ports: clk/rst_n (async clear to zero), we/waddr/wbe/wdata (byte-lane write),
//        raddr/rdata (AD read path), paddr/pdata (observation port).
module pci_target_mem
    import pci_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [3:0]       wbe,
    input  logic [BUS_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [BUS_W-1:0] rdata,
    input  logic [AW-1:0]    paddr,
    output logic [BUS_W-1:0] pdata
);

    logic [BUS_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];
    assign pdata = mem[paddr];

endmodule

// File: rtl/pci_target.sv
// Memory-backed PCI target: decodes the address phase, claims its device number, serves bursts.
// Latency: DEVSEL# low one cycle after the address edge; first TRDY# after 1+WAIT_CYCLES (+1 on reads).
// Backpressure: IRDY# high in DATA holds the word pointer and suppresses writes until the initiator is ready.
//
// Ports: clk, rst_n (async, active-low), frame/irdy (active-low bus controls), C_BE (command/byte enables),
//        AD (shared address/data), devsel/trdy (tristated responses), peek_addr/peek_data (memory observation).
module pci_target
    import pci_pkg::*;
#(
    parameter logic [1:0] DEV_ADDR    = 2'd0,
    parameter int         MEM_DEPTH   = 8,
    parameter int         WAIT_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame,
    input  logic                         irdy,
    input  logic [3:0]                   C_BE,
    inout  wire  [BUS_W-1:0]             AD,
    output wire                          devsel,
    output wire                          trdy,
    input  logic [$clog2(MEM_DEPTH)-1:0] peek_addr,
    output logic [BUS_W-1:0]             peek_data
);

    localparam int AW = $clog2(MEM_DEPTH);

    tgt_state_e       state_q, state_d;
    logic             is_rd_q, is_rd_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [2:0]       wcnt_q, wcnt_d;

    logic             hit;
    logic             rd_cmd;
    logic [2:0]       load;
    logic             mem_we;
    logic [BUS_W-1:0] mem_rdata;
    logic             own;

    assign rd_cmd = (C_BE == CMD_MEM_READ);
    assign hit    = !frame && (AD[1:0] == DEV_ADDR) && is_legal_cmd(C_BE);

    // Cycles TRDY# stays high after the address edge; reads add one turnaround cycle.
    assign load = 3'(WAIT_CYCLES) + {2'b00, rd_cmd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            is_rd_q <= 1'b0;
            ptr_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            is_rd_q <= is_rd_d;
            ptr_q   <= ptr_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        is_rd_d = is_rd_q;
        ptr_d   = ptr_q;
        wcnt_d  = wcnt_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    is_rd_d = rd_cmd;
                    ptr_d   = AD[2 +: AW];
                    // The claim cycle is itself the first TRDY#-high cycle, so with no
                    // wait at all the target enters DATA straight away and DEVSEL#/TRDY#
                    // fall together.
                    if (load == 3'd0) begin
                        state_d = DATA;
                    end else begin
                        state_d = CLAIM;
                        wcnt_d  = load - 3'd1;
                    end
                end
            end
            CLAIM: begin
                if (frame && irdy) begin
                    state_d = RELEASE;
                end else if (wcnt_q == 3'd0) begin
                    state_d = DATA;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (frame && irdy) begin
                    state_d = RELEASE;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                    if (wcnt_q == 3'd1) begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (!irdy) begin
                    mem_we = !is_rd_q;
                    ptr_d  = ptr_q + AW'(1);
                end
                // frame high ends the burst: either the final transfer or an abandon.
                if (frame) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    pci_target_mem #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (ptr_q),
        .wbe   (C_BE),
        .wdata (AD),
        .raddr (ptr_q),
        .rdata (mem_rdata),
        .paddr (peek_addr),
        .pdata (peek_data)
    );

    // Bus drivers: released in IDLE so other targets can share the lines.
    assign own    = (state_q != IDLE);
    assign devsel = own ? (state_q == RELEASE) : 1'bz;
    assign trdy   = own ? (state_q != DATA)    : 1'bz;
    assign AD     = (state_q == DATA && is_rd_q) ? mem_rdata : {BUS_W{1'bz}};

endmodule

// File: tb/tb_pci_target.sv
// Bench for pci_target: two targets (dev 1 zero-wait, dev 2 two-wait) on one shared bus.
// Latency: n/a.
// Backpressure: the initiator model inserts IRDY# stalls mid-burst.
`timescale 1ns/1ps
module tb_pci_target;
    import pci_pkg::*;

    localparam int DEPTH = 8;
    localparam int W1    = 0;
    localparam int W2    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame;
    logic        irdy;
    logic [3:0]  c_be;
    logic [31:0] ad_drv;
    logic        ad_oe;
    wire  [31:0] ad;
    wire         devsel;
    wire         trdy;
    logic [2:0]  pa0, pa1;
    logic [31:0] pd0, pd1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model [2][DEPTH];
    logic [31:0] xd [16];
    logic [3:0]  xb [16];

    always #5 clk = ~clk;

    assign ad = ad_oe ? ad_drv : 32'hzzzz_zzzz;
    pullup pu_devsel (devsel);
    pullup pu_trdy   (trdy);

    pci_target #(.DEV_ADDR(2'd1), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_t1 (
        .clk(clk), .rst_n(rst_n), .frame(frame), .irdy(irdy), .C_BE(c_be), .AD(ad),
        .devsel(devsel), .trdy(trdy), .peek_addr(pa0), .peek_data(pd0)
    );

    pci_target #(.DEV_ADDR(2'd2), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(W2)) u_t2 (
        .clk(clk), .rst_n(rst_n), .frame(frame), .irdy(irdy), .C_BE(c_be), .AD(ad),
        .devsel(devsel), .trdy(trdy), .peek_addr(pa1), .peek_data(pd1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_mem(input int t, input int w, input string tag);
        if (t == 0) begin
            pa0 = 3'(w);
            #1;
            chk(tag, pd0, model[0][w]);
        end else begin
            pa1 = 3'(w);
            #1;
            chk(tag, pd1, model[1][w]);
        end
    endtask

    task automatic chk_all(input string tag);
        for (int t = 0; t < 2; t++) begin
            for (int w = 0; w < DEPTH; w++) begin
                chk_mem(t, w, tag);
            end
        end
    endtask

    task automatic bus_idle();
        frame  = 1'b1;
        irdy   = 1'b1;
        ad_oe  = 1'b0;
        c_be   = 4'hF;
    endtask

    // One initiator transaction. Data/byte enables come from xd/xb. The initiator holds
    // IRDY# high for stall_len cycles before word stall_at; rst_at >= 0 pulls reset
    // just before transfer number rst_at.
    task automatic xact(input logic [1:0] dev, input logic [3:0] cmd, input int start,
                        input int n, input int stall_at, input int stall_len, input int rst_at);
        bit rd, hit, aborted;
        int t, wt, k, ptr, stalled, first_trdy, pend_w;
        rd  = (cmd == CMD_MEM_READ);
        hit = (dev == 2'd1 || dev == 2'd2) && (cmd == CMD_MEM_WRITE || rd);
        t   = (dev == 2'd2) ? 1 : 0;
        wt  = (t == 1) ? W2 : W1;

        @(negedge clk);
        frame  = 1'b0;
        irdy   = 1'b1;
        c_be   = cmd;
        ad_drv = $urandom;
        ad_drv[4:2] = 3'(start);
        ad_drv[1:0] = dev;
        ad_oe  = 1'b1;

        if (!hit) begin
            // Address held on the bus: every edge is another (missed) address phase.
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                chk("miss_bus", {30'd0, devsel, trdy}, 32'd3);
            end
            bus_idle();
            @(negedge clk);
            chk("miss_idle", {30'd0, devsel, trdy}, 32'd3);
            chk_all("miss_mem");
            return;
        end

        k = 0; ptr = start; stalled = 0; first_trdy = -1; pend_w = -1; aborted = 0;
        for (int cyc = 1; cyc <= 40 && k < n; cyc++) begin
            @(negedge clk);
            if (pend_w >= 0) begin
                chk_mem(t, pend_w, "wr_peek");
                pend_w = -1;
            end
            if (cyc == 1) chk("devsel_lat", {31'd0, devsel}, 32'd0);
            if (trdy == 1'b0 && first_trdy < 0) begin
                first_trdy = cyc;
                chk("trdy_lat", cyc, 1 + wt + int'(rd));
            end
            if (rst_at >= 0 && k == rst_at && trdy == 1'b0) begin
                rst_n = 1'b0;
                #1;
                chk("rst_bus", {30'd0, devsel, trdy}, 32'd3);
                bus_idle();
                aborted = 1;
                break;
            end
            if (k == stall_at && stalled < stall_len && trdy == 1'b0) begin
                stalled++;
                irdy   = 1'b1;
                c_be   = 4'hF;
                ad_oe  = !rd;
                ad_drv = $urandom;
            end else begin
                irdy   = 1'b0;
                frame  = (k == n - 1);
                c_be   = rd ? 4'hF : xb[k];
                ad_oe  = !rd;
                ad_drv = xd[k];
                if (trdy == 1'b0) begin
                    if (rd) begin
                        chk("rd_data", ad, model[t][ptr]);
                    end else begin
                        for (int b = 0; b < 4; b++) begin
                            if (xb[k][b]) model[t][ptr][8*b +: 8] = xd[k][8*b +: 8];
                        end
                        pend_w = ptr;
                    end
                    ptr = (ptr + 1) % DEPTH;
                    k++;
                end
            end
        end

        if (aborted) begin
            @(negedge clk);
            rst_n = 1'b1;
            for (int tt = 0; tt < 2; tt++)
                for (int w = 0; w < DEPTH; w++) model[tt][w] = '0;
            chk("rst_idle", {30'd0, devsel, trdy}, 32'd3);
            chk_all("rst_mem");
            return;
        end

        if (k < n) chk("xfer_timeout", k, n);
        @(negedge clk);
        if (pend_w >= 0) chk_mem(t, pend_w, "wr_peek");
        chk("release", {30'd0, devsel, trdy}, 32'd3);
        bus_idle();
        chk_all("mem");
    endtask

    initial begin
        logic [1:0] dev;
        logic [3:0] cmd;
        int         r, n, sa;

        for (int t = 0; t < 2; t++)
            for (int w = 0; w < DEPTH; w++) model[t][w] = '0;
        rst_n = 1'b0;
        pa0 = '0;
        pa1 = '0;
        ad_drv = '0;
        bus_idle();
        #1;
        chk("reset_bus", {30'd0, devsel, trdy}, 32'd3);
        chk_all("reset_mem");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full write then a partial overwrite of word 2 on dev 1.
        xd[0] = 32'hDEAD_BEEF; xb[0] = 4'b1111;
        xact(2'd1, CMD_MEM_WRITE, 2, 1, -1, 0, -1);
        xd[0] = 32'h1122_3344; xb[0] = 4'b0101;
        xact(2'd1, CMD_MEM_WRITE, 2, 1, -1, 0, -1);
        pa0 = 3'd2;
        #1;
        chk("partial_merge", pd0, 32'hDE22_BE44);

        // Preload words 6,7,0 and read them back as a wrapping burst.
        for (int i = 0; i < 3; i++) begin xd[i] = $urandom; xb[i] = 4'hF; end
        xact(2'd1, CMD_MEM_WRITE, 6, 3, -1, 0, -1);
        xact(2'd1, CMD_MEM_READ, 6, 3, -1, 0, -1);

        // Misses: unknown device, illegal command, unpopulated device number.
        xact(2'd3, CMD_MEM_WRITE, 1, 1, -1, 0, -1);
        xact(2'd1, 4'b0110, 2, 1, -1, 0, -1);
        xact(2'd0, CMD_MEM_READ, 0, 1, -1, 0, -1);

        // Two-wait target: write burst with a two-cycle stall, then read it back.
        for (int i = 0; i < 4; i++) begin xd[i] = $urandom; xb[i] = 4'hF; end
        xact(2'd2, CMD_MEM_WRITE, 5, 4, 2, 2, -1);
        xact(2'd2, CMD_MEM_READ, 5, 4, 1, 2, -1);

        for (int i = 0; i < 30; i++) begin
            r   = $urandom_range(0, 9);
            dev = (r < 4) ? 2'd1 : (r < 8) ? 2'd2 : (r == 8) ? 2'd0 : 2'd3;
            cmd = ($urandom_range(0, 5) == 0) ? 4'b0110 :
                  ($urandom_range(0, 1) != 0) ? CMD_MEM_READ : CMD_MEM_WRITE;
            n   = $urandom_range(1, 5);
            // 0000/0001 are excluded so data phases never look like a legal command.
            for (int j = 0; j < n; j++) begin
                xd[j] = $urandom;
                xb[j] = 4'($urandom_range(2, 15));
            end
            sa = (n > 1) ? $urandom_range(1, n - 1) : -1;
            xact(dev, cmd, $urandom_range(0, 7), n, sa, $urandom_range(0, 2), -1);
        end

        // Reset in the middle of a read burst on dev 1.
        for (int i = 0; i < 4; i++) begin xd[i] = $urandom | 32'h1; xb[i] = 4'hF; end
        xact(2'd1, CMD_MEM_WRITE, 0, 4, -1, 0, -1);
        xact(2'd1, CMD_MEM_READ, 0, 4, -1, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pci_target.md
# pci_target

Memory-backed PCI target that consumes the bus transactions generated by the initiator controller. It decodes the address phase, claims cycles addressed to its device number and answers with DEVSEL#/TRDY#. Read data is driven onto AD. Write data is stored under byte-enable control, and burst data phases advance a wrapping word pointer. It hangs on the shared AD/C_BE/FRAME#/IRDY# bus, alongside other targets.

## Interface
Parameters:
- DEV_ADDR, 2'd0: device number matched against AD[1:0] in the address phase.
- MEM_DEPTH, 8: 32-bit words of local storage; must be a power of two.
- WAIT_CYCLES, 0: extra cycles TRDY# stays high before the first data phase. Range 0–3.

Ports:
- clk  in  1: bus clock. All bus signals are sampled on the rising edge.
- rst_n  in  1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- frame  in  1: FRAME#, active-low.
- irdy  in  1: IRDY#, active-low.
- C_BE  in  4: command in the address phase, byte enables (active-high) in data phases.
- AD  inout  32: multiplexed address/data.
- devsel  out  1: DEVSEL#. Driven only while this target owns the cycle, otherwise high-Z.
- trdy  out  1: TRDY#. Driven only while this target owns the cycle, otherwise high-Z.
- peek_addr  in  $clog2(MEM_DEPTH): combinational memory observation address, for the bench.
- peek_data  out  32: contents of mem[peek_addr].

## Operation
- Command codes: 4'b0000 = memory write, 4'b0001 = memory read. Any other code is not claimed.
- Address decode: an address phase is a rising edge where the target is IDLE and frame is low.
- Hit: AD[1:0]==DEV_ADDR and the command is legal. Start pointer = AD[2 +: log2(MEM_DEPTH)].
- States:
  - IDLE: no hit, or no address phase → stay.
  - IDLE → CLAIM on a hit. Latch the command and the pointer.
  - CLAIM: devsel=0, trdy=1. Load the wait counter with WAIT_CYCLES, plus 1 for a read (turnaround). Go to WAIT when the counter is nonzero, else to DATA.
  - WAIT: devsel=0, trdy=1. Decrement; go to DATA when the counter reaches 0.
  - DATA: devsel=0, trdy=0.
    - Transfer = rising edge with irdy==0 && trdy==0.
    - Write transfer: mem[ptr] byte lanes with C_BE[i]==1 take AD[8i+7:8i].
    - Read: AD is driven with mem[ptr] for the whole DATA state.
    - Each transfer increments ptr modulo MEM_DEPTH (wrap-around).
    - A transfer with frame==1 is the last one → go to RELEASE.
    - No transfer (irdy high) → stay. Do not advance, do not write.
  - RELEASE: devsel=1, trdy=1 driven for one cycle, then IDLE (high-Z).
- Abandon: frame high and irdy high during CLAIM, WAIT or DATA → RELEASE with no transfer.
- The target never drives AD in IDLE, CLAIM, WAIT or RELEASE, or on writes.

## Timing
- Reset (async): state=IDLE, ptr=0, wait counter=0, memory cleared to 0. devsel/trdy/AD are high-Z immediately. Reset mid-transaction abandons it with no further memory writes.
- DEVSEL# latency: low in the cycle after the address edge (fast decode).
- First TRDY# low:
  - Write: address edge + 1 + WAIT_CYCLES.
  - Read: address edge + 2 + WAIT_CYCLES.
- Write data is visible on peek_data the cycle after its transfer edge.
- Read data for the next word appears on AD the cycle after each transfer edge. Zero-wait bursts sustain one word per clock.
- A new address phase is not accepted until the cycle after RELEASE.

## Structure
- Shared package pci_pkg:
  - command constants CMD_MEM_WRITE and CMD_MEM_READ;
  - the target state enum (IDLE, CLAIM, WAIT, DATA, RELEASE);
  - the bus width constant (32).
- Sub-module pci_target_mem:
  - MEM_DEPTH×32 RAM;
  - synchronous byte-enable write, asynchronous read port for the AD path, a second asynchronous read port for peek;
  - async active-low clear.
- The top level holds the FSM, the decode, the wait counter and the tristate drivers.

## Test plan
- Single write, WAIT_CYCLES=0, DEV_ADDR=1: address AD=32'h0000_0009 (dev 1, word 2), C_BE=0000; data 32'hDEAD_BEEF, C_BE=1111 → devsel low at +1, trdy low at +1, peek mem[2]=DEADBEEF, RELEASE then Z.
- Partial write over the previous contents: C_BE=0101, data 32'h1122_3344 to word 2 → mem[2]=32'hDE22_BE44.
- Read burst of 3 from word 6, MEM_DEPTH=8, preloaded mem[6], mem[7], mem[0] → trdy low at +2, AD returns mem[6], mem[7], mem[0] on consecutive transfers (wrap), frame released on the third.
- Miss: AD[1:0]=2 with DEV_ADDR=1, or command 4'b0110 → devsel/trdy/AD stay Z for the whole transaction, memory unchanged.
- Wait and stall: WAIT_CYCLES=2 write burst, irdy held high for 2 cycles mid-burst → first trdy at +3, no write and no pointer advance during the stall, correct words afterwards.
- Reset mid-burst: assert rst_n=0 during DATA of a read → outputs Z in the same cycle, state IDLE, memory all zero after release.
